// File: rtl/hex_mode_display.sv
// Mode-selectable multi-digit seven-segment controller: direct switches, debounced
// up/down key counter, free-running timed counter, or blank. Active-low HEX outputs.
module hex_mode_display #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned DEBOUNCE = 500000,
  parameter int unsigned LZB      = 0
) (
  input  logic                  CLOCK_50,
  input  logic                  RESETn,
  input  logic [9:0]            SW,
  input  logic                  KEY_INC,
  input  logic                  KEY_CLR,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam int unsigned PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_MANUAL = 2'b01,
    MODE_TIMED  = 2'b10,
    MODE_BLANK  = 2'b11
  } mode_t;

  // Only mode and value bits are synchronised; SW[7:4] has no function.
  logic [5:0]     sw_meta, sw_sync;
  logic [1:0]     key_meta, key_sync;   // [0] = INC, [1] = CLR
  logic [1:0]     key_level, press;
  logic [CW-1:0]  stab [2];
  logic [W-1:0]   mcount, tcount;
  logic [PW-1:0]  presc;
  logic [7*DIGITS-1:0] hex_next;
  mode_t          mode;
  logic           unused_sw;

  assign unused_sw = ^SW[7:4];
  assign mode      = mode_t'(sw_sync[5:4]);

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      key_meta <= '1;
      key_sync <= '1;
    end else begin
      sw_meta  <= {SW[9:8], SW[3:0]};
      sw_sync  <= sw_meta;
      key_meta <= {KEY_CLR, KEY_INC};
      key_sync <= key_meta;
    end
  end

  // The level flips on the cycle after the stability count reaches DEBOUNCE;
  // press is registered alongside the 1->0 flip so it is high the following cycle.
  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      key_level <= '1;
      press     <= '0;
      for (int unsigned k = 0; k < 2; k++) stab[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < 2; k++) begin
        press[k] <= 1'b0;
        if (key_sync[k] == key_level[k]) begin
          stab[k] <= '0;
        end else if (stab[k] == CW'(DEBOUNCE)) begin
          key_level[k] <= key_sync[k];
          stab[k]      <= '0;
          press[k]     <= key_level[k];
        end else begin
          stab[k] <= stab[k] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      mcount <= '0;
      tcount <= '0;
      presc  <= '0;
    end else begin
      case (mode)
        MODE_MANUAL: begin
          if (press[1])      mcount <= '0;
          else if (press[0]) mcount <= sw_sync[0] ? mcount - W'(1) : mcount + W'(1);
        end
        MODE_TIMED: begin
          if (press[1]) begin
            tcount <= '0;
            presc  <= '0;
          end else if (presc == PW'(TICK_DIV - 1)) begin
            presc  <= '0;
            tcount <= tcount + W'(1);
          end else begin
            presc  <= presc + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    logic [W-1:0] value;
    logic [3:0]   nib;
    logic         leading;
    hex_next = '1;
    value    = '0;
    nib      = '0;
    leading  = 1'b1;
    case (mode)
      MODE_DIRECT: hex_next[6:0] = glyph(sw_sync[3:0]);
      MODE_MANUAL, MODE_TIMED: begin
        value = (mode == MODE_TIMED) ? tcount : mcount;
        // Walk from the top digit down so leading-zero state is known per digit.
        for (int unsigned j = 0; j < DIGITS; j++) begin
          nib = value[4*(DIGITS-1-j) +: 4];
          if (nib != 4'h0) leading = 1'b0;
          if (LZB == 0 || !leading || j == DIGITS - 1)
            hex_next[7*(DIGITS-1-j) +: 7] = glyph(nib);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) HEX <= '1;
    else         HEX <= hex_next;
  end

endmodule

// File: tb/tb_hex_mode_display.sv
// Directed bench for hex_mode_display (DIGITS=4, TICK_DIV=4, DEBOUNCE=3) with
// LZB=0 and LZB=1 instances sharing the same stimulus.
module tb_hex_mode_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  sw;
  logic        key_inc, key_clr;
  logic [27:0] hex, hex_lzb;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  hex_mode_display #(.DIGITS(4), .TICK_DIV(4), .DEBOUNCE(3), .LZB(0)) dut (
    .CLOCK_50(clk), .RESETn(rst_n), .SW(sw),
    .KEY_INC(key_inc), .KEY_CLR(key_clr), .HEX(hex)
  );

  hex_mode_display #(.DIGITS(4), .TICK_DIV(4), .DEBOUNCE(3), .LZB(1)) dut_lzb (
    .CLOCK_50(clk), .RESETn(rst_n), .SW(sw),
    .KEY_INC(key_inc), .KEY_CLR(key_clr), .HEX(hex_lzb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [27:0] got, input logic [27:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Clean press: hold low long enough to debounce, release long enough to settle.
  task automatic press_inc();
    key_inc = 1'b0;
    cycles(8);
    key_inc = 1'b1;
    cycles(10);
  endtask

  initial begin
    rst_n   = 1'b0;
    sw      = '0;
    key_inc = 1'b1;
    key_clr = 1'b1;
    cycles(2);
    check("reset_hex",     hex,     {7'h7F, 7'h7F, 7'h7F, 7'h7F});
    check("reset_hex_lzb", hex_lzb, {7'h7F, 7'h7F, 7'h7F, 7'h7F});

    // Direct mode: SW=0 still synchronised for two edges, then 'A' appears.
    rst_n = 1'b1;
    sw    = 10'b00_0000_1010;
    cycles(2);
    check("direct_pre",  hex, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    cycles(1);
    check("direct_A",    hex, {7'h7F, 7'h7F, 7'h7F, 7'h08});

    sw = 10'b11_0000_0000;
    cycles(3);
    check("blank_mode",  hex, {7'h7F, 7'h7F, 7'h7F, 7'h7F});

    // Manual counter up
    sw = 10'b01_0000_0000;
    cycles(3);
    check("man_zero",     hex,     {7'h40, 7'h40, 7'h40, 7'h40});
    check("man_zero_lzb", hex_lzb, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    repeat (5) press_inc();
    check("man_five",     hex,     {7'h40, 7'h40, 7'h40, 7'h12});
    check("man_five_lzb", hex_lzb, {7'h7F, 7'h7F, 7'h7F, 7'h12});

    // Manual counter down through zero
    sw = 10'b01_0000_0001;
    cycles(3);
    repeat (6) press_inc();
    check("man_ffff",     hex,     {7'h0E, 7'h0E, 7'h0E, 7'h0E});
    check("man_ffff_lzb", hex_lzb, {7'h0E, 7'h0E, 7'h0E, 7'h0E});

    // Bounce then hold: one increment FFFF -> 0000, HEX changes on 8th edge after fall
    sw = 10'b01_0000_0000;
    cycles(3);
    for (int i = 0; i < 20; i++) begin
      key_inc = ((i % 4) < 2) ? 1'b0 : 1'b1;
      cycles(1);
    end
    check("deb_bounce",  hex, {7'h0E, 7'h0E, 7'h0E, 7'h0E});
    key_inc = 1'b0;
    cycles(7);
    check("deb_before",  hex, {7'h0E, 7'h0E, 7'h0E, 7'h0E});
    cycles(1);
    check("deb_at",      hex, {7'h40, 7'h40, 7'h40, 7'h40});
    cycles(2);
    key_inc = 1'b1;
    cycles(10);
    check("deb_release", hex, {7'h40, 7'h40, 7'h40, 7'h40});

    // Timed counter: 40 counting edges -> tcount = A
    sw = 10'b10_0000_0000;
    cycles(43);
    check("timed_A",     hex,     {7'h40, 7'h40, 7'h40, 7'h08});
    check("timed_A_lzb", hex_lzb, {7'h7F, 7'h7F, 7'h7F, 7'h08});

    sw = 10'b01_0000_0000;
    cycles(20);
    check("mode01_hold", hex, {7'h40, 7'h40, 7'h40, 7'h40});

    // Prescaler was left at 3, so the first counting edge on return ticks A -> B
    sw = 10'b10_0000_0000;
    cycles(3);
    check("timed_resume", hex, {7'h40, 7'h40, 7'h40, 7'h08});
    cycles(1);
    check("timed_B",      hex, {7'h40, 7'h40, 7'h40, 7'h03});

    // CLR pulse lands on the edge where the prescaler is 3 (would tick C -> D)
    key_clr = 1'b0;
    cycles(7);
    check("clr_before",    hex, {7'h40, 7'h40, 7'h40, 7'h46});
    cycles(1);
    check("clr_zero",      hex, {7'h40, 7'h40, 7'h40, 7'h40});
    key_clr = 1'b1;
    cycles(3);
    check("clr_no_tick",   hex, {7'h40, 7'h40, 7'h40, 7'h40});
    cycles(1);
    check("clr_next_tick", hex, {7'h40, 7'h40, 7'h40, 7'h79});

    // Run to tcount = 7, then a short asynchronous reset
    cycles(24);
    check("pre_rst_7",   hex, {7'h40, 7'h40, 7'h40, 7'h78});
    rst_n = 1'b0;
    #1;
    check("rst_async",   hex, {7'h7F, 7'h7F, 7'h7F, 7'h7F});
    #3;
    rst_n = 1'b1;
    cycles(1);
    check("rst_sync_sw", hex, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    cycles(2);
    check("rst_restart", hex, {7'h40, 7'h40, 7'h40, 7'h40});
    cycles(3);
    check("rst_no_tick", hex, {7'h40, 7'h40, 7'h40, 7'h40});
    cycles(1);
    check("rst_tick1",   hex, {7'h40, 7'h40, 7'h40, 7'h79});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hex_mode_display.md
# hex_mode_display

Multi-digit, mode-selectable seven-segment display controller for the DE1-SoC HEX outputs. It is the parametrised successor to the single-digit lab display. Switch bits SW[9:8] select one of four modes: direct switch display, a debounced up/down key counter, a free-running timed counter, or blank. Both counters are DIGITS hex digits wide, keep their values while another mode is shown, and support optional leading-zero blanking. The block sits at the board top level, between the raw SW/KEY/CLOCK_50 pins and the HEX pins.

## Interface
- DIGITS, 4: number of hex digits driven; each counter is 4*DIGITS bits.
- TICK_DIV, 50000000: CLOCK_50 cycles per timed-counter increment (≥2).
- DEBOUNCE, 500000: consecutive stable cycles needed before a key level is accepted (≥1).
- LZB, 0: 1 = blank leading zero digits in counter modes. Digit 0 is always shown.

- CLOCK_50  in  1  sole clock, rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- SW  in  10  raw switches. SW[9:8] = mode; SW[3:0] = direct value; SW[0] = count direction in mode 01.
- KEY_INC  in  1  raw pushbutton, active-low (pressed = 0). Step key.
- KEY_CLR  in  1  raw pushbutton, active-low. Clears the counter of the active mode.
- HEX  out  7*DIGITS  active-low segments. Digit i = HEX[7i+6:7i], bit order {g,f,e,d,c,b,a}.

## Operation
- SW, KEY_INC and KEY_CLR each pass through a 2-FF synchroniser. Everything after the synchronisers uses only the synchronised values.
- Debouncer, one per key:
  - Holds an accepted level, reset value 1 (released).
  - A stability counter runs while the synchronised input differs from the accepted level, and clears whenever they match.
  - After DEBOUNCE consecutive differing cycles, the accepted level flips.
  - An accepted 1→0 flip produces a one-cycle press pulse.
- Mode 00 (direct): digit 0 shows SW[3:0]. All other digits are blank. Key pulses are ignored.
- Mode 01 (manual counter):
  - An INC pulse steps mcount by +1 when SW[0]=0, or by −1 when SW[0]=1.
  - Modulo 2^(4*DIGITS): all-F → 0 on increment, 0 → all-F on decrement.
  - A CLR pulse sets mcount to 0.
- Mode 10 (timed counter):
  - The prescaler counts 0..TICK_DIV−1. When it reaches TICK_DIV−1 it returns to 0 and tcount increments (same wrap rule as mcount).
  - A CLR pulse zeroes both tcount and the prescaler. An INC pulse is ignored.
- Mode 11: all digits blank. The prescaler and both counters hold.
- Outside their own mode, mcount, tcount and the prescaler hold their values. There is no reset on mode entry.
- Simultaneous events: CLR beats a step or tick in the same cycle.
- Leading-zero blanking (LZB=1, modes 01/10): digits above the most significant non-zero digit are blank. A value of 0 shows only digit 0 as "0".
- Glyphs, active-low hex:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - blank=7F

## Timing
- Reset (RESETn=0, asynchronous):
  - HEX = all 7F.
  - mcount, tcount, prescaler and stability counters = 0.
  - Accepted key levels = 1.
  - Synchronisers = 0 for SW, 1 for keys.
- HEX is fully registered. It reflects the internal state from the previous cycle.
- SW change → HEX update: 3 edges (2 sync + output register).
- Key press latency:
  - Raw key falls before edge 0.
  - The synchronised value is 0 from edge 2.
  - The accepted level falls at edge 2+DEBOUNCE, and the press pulse is high during the following cycle.
  - The counter updates at edge 3+DEBOUNCE. HEX updates at edge 4+DEBOUNCE.
- Bounce: any return to the accepted level before DEBOUNCE cycles restarts the count, so no pulse is produced. Holding the key gives exactly one pulse. Release produces no pulse.
- Tick: in continuous mode 10, tcount increments once every TICK_DIV cycles. HEX follows one edge later.
- Mode change while a key is mid-debounce: the debouncer continues. The resulting pulse acts per the mode in effect on the pulse cycle.
- Reset asserted mid-operation: immediate return to reset values. Operation resumes from the first edge after release.

## Test plan
All scenarios use DIGITS=4, TICK_DIV=4, DEBOUNCE=3.

- Reset and direct mode:
  - RESETn low → HEX all 7F.
  - Release, then SW = 00_0000_1010 → within 3 edges digit0 = 08 and digits 1–3 = 7F.
  - SW mode 11 → all 7F.
- Manual counter:
  - Mode 01, SW[0]=0, five clean INC presses → mcount 5, digits = 12,40,40,40 (LZB=0). With LZB=1, digits 1–3 = 7F.
  - SW[0]=1, six presses → FFFF, all digits 0E.
- Debounce: KEY_INC toggled 0/1 every 2 cycles for 20 cycles, then held low for 10 cycles → exactly one increment, occurring at edge 3+DEBOUNCE after the final fall.
- Timed counter: mode 10 for 40 cycles → tcount = 10 (hex A), digit0 = 08.
  - Switch to mode 01 for 20 cycles, then back → count resumes from A, not 0.
- Clear priority: in mode 10, align a CLR pulse with the prescaler at 3 → tcount = 0 and prescaler = 0 the next cycle, with no increment. Next tick occurs 4 cycles later.
- Async reset mid-count: assert RESETn for half a cycle at tcount = 7 → HEX all 7F immediately. tcount restarts from 0.
